// File: rtl/inj_pkg.sv
// Shared types and default timing for the injector peak/hold sequencer.
// The scheduler uses the same defaults so both sides agree on pulse timing.
package inj_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEAK  = 2'd1,
    HOLD  = 2'd2,
    BLANK = 2'd3
  } inj_state_t;

  localparam int c_WIDTH_DEF       = 16;
  localparam int c_PEAK_COUNTS_DEF = 20;
  localparam int c_HOLD_PERIOD_DEF = 10;
  localparam int c_HOLD_ON_DEF     = 4;
  localparam int c_BLANK_DEF       = 8;

endpackage

// File: rtl/inj_hold_pwm.sv
// Hold-phase PWM: wrapping phase counter with synchronous restart.
// on_next reports the on/off decision for the phase being loaded this edge.
module inj_hold_pwm
  import inj_pkg::*;
#(
  parameter int c_WIDTH       = c_WIDTH_DEF,
  parameter int c_HOLD_PERIOD = c_HOLD_PERIOD_DEF,
  parameter int c_HOLD_ON     = c_HOLD_ON_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic on_next
);

  localparam logic [c_WIDTH-1:0] c_last   = c_WIDTH'(c_HOLD_PERIOD - 1);
  localparam logic [c_WIDTH-1:0] c_on_cnt = c_WIDTH'(c_HOLD_ON);
  localparam logic [c_WIDTH-1:0] c_one    = c_WIDTH'(1);

  logic [c_WIDTH-1:0] phase;
  logic [c_WIDTH-1:0] phase_nxt;

  always_comb begin
    phase_nxt = phase;
    if (restart) begin
      phase_nxt = '0;
    end else if (enable) begin
      phase_nxt = (phase == c_last) ? '0 : phase + c_one;
    end
  end

  assign on_next = (phase_nxt < c_on_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else begin
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/inj_peak_hold_ctrl.sv
// Single-channel peak-and-hold injector sequencer with registered outputs.
// state | meaning
// IDLE  | ready for a request, gate off
// PEAK  | full-on drive, peak current threshold selected
// HOLD  | PWM-chopped drive, hold current threshold selected
// BLANK | gate off for flyback; always runs to completion
module inj_peak_hold_ctrl
  import inj_pkg::*;
#(
  parameter int c_WIDTH       = c_WIDTH_DEF,
  parameter int c_PEAK_COUNTS = c_PEAK_COUNTS_DEF,
  parameter int c_HOLD_PERIOD = c_HOLD_PERIOD_DEF,
  parameter int c_HOLD_ON     = c_HOLD_ON_DEF,
  parameter int c_BLANK       = c_BLANK_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic [c_WIDTH-1:0] i_duration,
  input  logic               i_abort,
  output logic               o_ready,
  output logic               o_drive,
  output logic               o_hold_sel,
  output logic               o_done,
  output logic               o_aborted
);

  localparam logic [c_WIDTH-1:0] c_one      = c_WIDTH'(1);
  localparam logic [c_WIDTH-1:0] c_peak_end = c_WIDTH'(c_PEAK_COUNTS);
  localparam logic [c_WIDTH-1:0] c_blank_ld = c_WIDTH'(c_BLANK);

  inj_state_t state, state_nxt;
  logic [c_WIDTH-1:0] dur, dur_nxt;
  logic [c_WIDTH-1:0] elapsed, elapsed_nxt;
  logic [c_WIDTH-1:0] peak_cnt, peak_nxt;
  logic [c_WIDTH-1:0] blank_cnt, blank_nxt;
  logic aborted_nxt, done_nxt, hold_on_nxt;

  function automatic logic [c_WIDTH-1:0] sat_inc(input logic [c_WIDTH-1:0] v);
    return (&v) ? v : v + c_one;
  endfunction

  always_comb begin
    state_nxt   = state;
    dur_nxt     = dur;
    elapsed_nxt = elapsed;
    peak_nxt    = peak_cnt;
    blank_nxt   = blank_cnt;
    aborted_nxt = o_aborted;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start && !i_abort) begin
          if (i_duration != '0) begin
            dur_nxt     = i_duration;
            elapsed_nxt = c_one;
            peak_nxt    = c_one;
            aborted_nxt = 1'b0;
            state_nxt   = PEAK;
          end else begin
            blank_nxt = c_blank_ld;
            state_nxt = BLANK;
          end
        end
      end
      PEAK, HOLD: begin
        // elapsed counts the cycle being entered, so equality closes the window
        if (i_abort || elapsed == dur) begin
          aborted_nxt = o_aborted | i_abort;
          blank_nxt   = c_blank_ld;
          state_nxt   = BLANK;
        end else begin
          elapsed_nxt = sat_inc(elapsed);
          if (state == PEAK) begin
            peak_nxt = sat_inc(peak_cnt);
            if (peak_cnt == c_peak_end) state_nxt = HOLD;
          end
        end
      end
      BLANK: begin
        if (blank_cnt <= c_one) begin
          blank_nxt = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          blank_nxt = blank_cnt - c_one;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  inj_hold_pwm #(
    .c_WIDTH      (c_WIDTH),
    .c_HOLD_PERIOD(c_HOLD_PERIOD),
    .c_HOLD_ON    (c_HOLD_ON)
  ) u_hold_pwm (
    .clk    (i_clock),
    .rst_n  (i_reset_n),
    .enable (state == HOLD),
    .restart(state_nxt == HOLD && state != HOLD),
    .on_next(hold_on_nxt)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      dur        <= '0;
      elapsed    <= '0;
      peak_cnt   <= '0;
      blank_cnt  <= '0;
      o_ready    <= 1'b1;
      o_drive    <= 1'b0;
      o_hold_sel <= 1'b0;
      o_done     <= 1'b0;
      o_aborted  <= 1'b0;
    end else begin
      state      <= state_nxt;
      dur        <= dur_nxt;
      elapsed    <= elapsed_nxt;
      peak_cnt   <= peak_nxt;
      blank_cnt  <= blank_nxt;
      o_ready    <= (state_nxt == IDLE);
      o_drive    <= (state_nxt == PEAK) || (state_nxt == HOLD && hold_on_nxt);
      o_hold_sel <= (state_nxt == HOLD);
      o_done     <= done_nxt;
      o_aborted  <= aborted_nxt;
    end
  end

endmodule
